// File: rtl/demux_nbit_1to4_q.sv
// Buffered 1-to-4 valid/ready demultiplexer with a 2-entry FIFO per lane.
// Optional accepted-transfer counter on xfer_count when DEMUX_XFER_COUNT_EN is defined.

module demux_nbit_1to4_q_lane #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [n-1:0] push_data,
    input  logic         pop_ready,
    output logic         full,
    output logic         valid,
    output logic [n-1:0] head
);
    logic [1:0][n-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              pop;

    assign pop   = valid & pop_ready;
    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: head is only observed behind valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

module demux_nbit_1to4_q #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic         in_ready,
    output logic [3:0]   out_valid,
    output logic [n-1:0] out_data0,
    output logic [n-1:0] out_data1,
    output logic [n-1:0] out_data2,
    output logic [n-1:0] out_data3,
    input  logic [3:0]   out_ready,
    output logic [15:0]  xfer_count
);
    logic [3:0]        full;
    logic [3:0][n-1:0] head;
    logic              accept;

    // Readiness comes from registered occupancy only, so a full lane that is
    // draining this cycle still refuses the transfer.
    assign in_ready = rst_n & ~full[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        demux_nbit_1to4_q_lane #(.n(n)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (accept && (in_sel == 2'(k))),
            .push_data (in_data),
            .pop_ready (out_ready[k]),
            .full      (full[k]),
            .valid     (out_valid[k]),
            .head      (head[k])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

`ifdef DEMUX_XFER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      xfer_count <= 16'h0000;
        else if (accept) xfer_count <= xfer_count + 16'h0001;
    end
`else
    assign xfer_count = 16'h0000;
`endif
endmodule

// File: tb/tb_demux_nbit_1to4_q.sv
// Directed self-checking bench for demux_nbit_1to4_q (n=16).
module tb_demux_nbit_1to4_q;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_ready = '0;
    logic [15:0] xfer_count;
    int          n_cmp = 0;
    int          n_err = 0;

    demux_nbit_1to4_q #(.n(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lane_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hDEAD; out_ready = '0;
        step(); step();
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL reset_xfer_count got %h exp 0000", xfer_count); end
        rst_n = 1'b1; in_data = 16'h1234;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL first_xfer_valid got %b exp 0100", out_valid); end
        n_cmp++; if (out_data2 !== 16'h1234) begin n_err++; $display("FAIL first_xfer_data got %h exp 1234", out_data2); end
        out_ready = 4'b0100;
        step();
        out_ready = '0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL first_xfer_drain got %b exp 0000", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = '0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'hA001;
        step();
        in_data = 16'hA002;
        step();
        in_valid = 1'b0; in_sel = 2'd1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        in_sel = 2'd0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_other_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL bp_valid got %b exp 0010", out_valid); end
        n_cmp++; if (out_data1 !== 16'hA001) begin n_err++; $display("FAIL bp_head0 got %h exp a001", out_data1); end
        out_ready = 4'b0010;
        step();
        n_cmp++; if (out_data1 !== 16'hA002 || out_valid !== 4'b0010) begin n_err++; $display("FAIL bp_head1 got %h/%b exp a002/0010", out_data1, out_valid); end
        step();
        out_ready = '0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL bp_empty got %b exp 0000", out_valid); end
    endtask

    task automatic test_full_concurrent();
        out_ready = '0;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 16'hC001;
        step();
        in_data = 16'hC002;
        step();
        out_ready = 4'b1000; in_data = 16'hC003; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fc_full_dequeue_ready got %b exp 0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fc_ready_after got %b exp 1", in_ready); end
        n_cmp++; if (out_data3 !== 16'hC002) begin n_err++; $display("FAIL fc_head got %h exp c002", out_data3); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data3 !== 16'hC003 || out_valid !== 4'b1000) begin n_err++; $display("FAIL fc_new_head got %h/%b exp c003/1000", out_data3, out_valid); end
        step();
        out_ready = '0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL fc_drain got %b exp 0000", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 2'(i % 4); in_data = 16'(i + 1); #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== (4'b0001 << (i % 4)) || lane_data(i % 4) !== 16'(i + 1))
                begin n_err++; $display("FAIL stream_out[%0d] got %b/%h exp %b/%h", i, out_valid, lane_data(i % 4), 4'b0001 << (i % 4), 16'(i + 1)); end
        end
        in_valid = 1'b0;
        step();
        out_ready = '0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL stream_drain got %b exp 0000", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = '0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hD001; step();
        in_data = 16'hD002; step();
        in_sel = 2'd2; in_data = 16'hD003; step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0101) begin n_err++; $display("FAIL ar_before got %b exp 0101", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin n_err++; $display("FAIL ar_immediate got %b/%b exp 0000/0", out_valid, in_ready); end
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hE001;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0001 || out_data0 !== 16'hE001) begin n_err++; $display("FAIL ar_fresh got %b/%h exp 0001/e001", out_valid, out_data0); end
        out_ready = 4'b0001;
        step();
        out_ready = '0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL ar_drain got %b exp 0000", out_valid); end
    endtask

    task automatic test_xfer_count();
`ifdef DEMUX_XFER_COUNT_EN
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        out_ready = 4'b1111;
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_sel = 2'(i % 4); in_data = 16'(i);
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL xfer_preload got %h exp ffff", xfer_count); end
        step();
        n_cmp++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL xfer_idle_hold got %h exp ffff", xfer_count); end
        in_valid = 1'b1; in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL xfer_wrap got %h exp 0000", xfer_count); end
        step();
        out_ready = '0;
`else
        n_cmp++; if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL xfer_tied got %h exp 0000", xfer_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_full_concurrent();
        test_back_to_back();
        test_async_reset();
        test_xfer_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
